// File: rtl/fib_key_checker.sv
`default_nettype none
// ============================================================================
// Module      : fib_key_checker
// Description : Serial key checker for the additive-sequence puzzle datapath.
//               Generates a Fibonacci-style sequence of TERM_W-bit terms from
//               two seeds and compares it bit-serially (one bit per clock)
//               against a latched KEY_W-bit key. Reports pass/fail, mismatch
//               count and first failing bit index via a start/done handshake.
//               Optional build macro FIB_CHECK_EARLY_ABORT_EN: when defined,
//               the first mismatch ends the run immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_key_checker #(
    parameter int TERM_W = 4,
    parameter int KEY_W  = 32,
    parameter int SEED_A = 1,
    parameter int SEED_B = 1
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic                       start,
    input  logic [KEY_W-1:0]           key_in,
    output logic                       busy,
    output logic                       done,
    output logic                       win,
    output logic [$clog2(KEY_W+1)-1:0] mismatch_cnt,
    output logic [$clog2(KEY_W)-1:0]   first_fail_idx
);

    localparam int c_CNT_W = $clog2(KEY_W+1);
    localparam int c_IDX_W = $clog2(KEY_W);
    localparam int c_WIN_W = 2*TERM_W;
    localparam int c_K_W   = $clog2(c_WIN_W);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(KEY_W-1);
    localparam logic [c_K_W-1:0]   c_K_LAST   = c_K_W'(c_WIN_W-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_W-1:0]     key_q,   key_d;
    logic [TERM_W-1:0]    r1_q,    r1_d;
    logic [TERM_W-1:0]    r2_q,    r2_d;
    logic [c_IDX_W-1:0]   idx_q,   idx_d;
    logic [c_K_W-1:0]     k_q,     k_d;
    logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [c_IDX_W-1:0]   ffi_q,   ffi_d;
    logic                 win_q,   win_d;

    logic [c_WIN_W-1:0]   w_window;
    logic                 w_miss;
    logic                 w_abort;

    // Current compare window and the per-bit mismatch against the latched key.
    assign w_window = {r2_q, r1_q};
    assign w_miss   = (w_window[k_q] != key_q[idx_q]);

`ifdef FIB_CHECK_EARLY_ABORT_EN
    assign w_abort = w_miss;
`else
    assign w_abort = 1'b0;
`endif

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            ffi_q   <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            ffi_q   <= ffi_d;
            win_q   <= win_d;
        end
    end

    // Next-state logic: accept in IDLE, one compare per cycle in CHECK, one-cycle DONE.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        idx_d   = idx_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        ffi_d   = ffi_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    key_d   = key_in;
                    r1_d    = TERM_W'(SEED_A);
                    r2_d    = TERM_W'(SEED_B);
                    idx_d   = '0;
                    k_d     = '0;
                    cnt_d   = '0;
                    ffi_d   = '0;
                    win_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if (w_miss) begin
                    cnt_d = cnt_q + 1'b1;
                    // Only the first mismatch of a run records its index.
                    if (cnt_q == '0) begin
                        ffi_d = idx_q;
                    end
                end
                idx_d = idx_q + 1'b1;
                // Window fully consumed: advance the sequence, carry dropped on purpose.
                if (k_q == c_K_LAST) begin
                    k_d  = '0;
                    r1_d = r2_q;
                    r2_d = r1_q + r2_q;
                end else begin
                    k_d = k_q + 1'b1;
                end
                // Verdict is registered on entry to DONE so it is valid with the done pulse.
                if ((idx_q == c_IDX_LAST) || w_abort) begin
                    state_d = S_DONE;
                    win_d   = (cnt_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy           = (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign win            = win_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffi_q;

endmodule
`default_nettype wire
